ps2_scancode_rx: RTL
====================

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning consecutive equal samples needed to accept a PS/2 line change (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000, meaning maximum clk cycles between PS/2 clock falling edges inside a frame (2 ms at 100 MHz).
REQ-003 SHALL have parameter DEPTH, default 8, meaning scancode FIFO entries (power of two, at least 2).
REQ-004 SHALL have parameter HIST_BYTES, default 4, meaning bytes held in the raw history register.
REQ-005 SHALL have port clk, input, 1, meaning single system clock (CLK100MHZ); all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have ports ps2_clk and ps2_data, input, 1 each, meaning raw asynchronous PS/2 lines.
REQ-008 SHALL have ports code_valid (output, 1) and code_ready (input, 1), meaning the FIFO-head handshake.
REQ-009 SHALL have ports code_data (output, 8), code_ext (output, 1) and code_brk (output, 1), meaning FIFO-head byte, E0-prefixed flag and F0-prefixed flag.
REQ-010 SHALL have port keycode_hist, output, 8*HIST_BYTES, meaning the most recent byte in [7:0] and older bytes in higher bytes.
REQ-011 SHALL have port fifo_count, output, $clog2(DEPTH+1), meaning FIFO occupancy.
REQ-012 SHALL have ports err_parity, err_frame and overflow, output, 1 each, meaning one-cycle error pulses.

Function
REQ-013 SHALL pass each PS/2 line through a 2-flop synchroniser, then a filter whose output changes only after FILTER_LEN consecutive samples that differ from the current output.
REQ-014 SHALL generate a one-cycle fall strobe when the filtered ps2_clk goes 1->0, and SHALL sample filtered ps2_data in that same cycle.
REQ-015 SHALL implement the FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on a fall strobe.
REQ-016 SHALL, in IDLE, enter DATA only when the sampled start bit is 0; a start bit of 1 SHALL leave the FSM in IDLE with no error.
REQ-017 SHALL, in DATA, shift in 8 bits LSB first, then go to PARITY, where it captures the parity bit, then go to STOP.
REQ-018 SHALL, in STOP, treat the frame as valid when the stop bit is 1 and the parity check passes; a stop bit of 0 SHALL discard the byte and pulse err_frame.
REQ-019 SHALL count cycles since the last fall strobe while the FSM is not in IDLE; on reaching TIMEOUT_CYCLES it SHALL discard the partial byte, return to IDLE and pulse err_frame.
REQ-020 SHALL shift every valid byte, prefixes included and repeats not suppressed, into keycode_hist.
REQ-021 SHALL treat a valid 0xE0 as a prefix that sets the pending ext flag, and a valid 0xF0 as a prefix that sets the pending brk flag; prefixes SHALL NOT be pushed.
REQ-022 SHALL push every other valid byte as {ext,brk,byte} and clear both pending flags.
REQ-023 SHALL make the FIFO first-word-fall-through: code_valid = (count != 0); code_data, code_ext and code_brk show the head entry.
REQ-024 SHALL perform the push on the edge that samples the stop bit, so that code_valid rises one cycle after that edge when the FIFO was empty.
REQ-025 SHALL pop when code_valid && code_ready.
REQ-026 SHALL, on a push while full with no pop, drop the new entry, leave the contents unchanged and pulse overflow.
REQ-027 SHALL, on a simultaneous push and pop while full, perform both with the count unchanged.
REQ-028 SHALL treat a pop request while empty as a no-op.
REQ-029 SHALL wrap the read and write pointers modulo DEPTH.

Reset
REQ-030 SHALL, on rst_n low, immediately drive the FSM to IDLE, zero all counters and pointers, fifo_count=0, code_valid=0, code_data=0x00, code_ext=0, code_brk=0, keycode_hist=0, all error pulses 0, pending flags 0, and filter outputs 1 (idle line high).
REQ-031 SHALL, on reset mid-frame, lose the partial byte and all FIFO contents without raising any error pulse.

Configuration
REQ-032 SHALL, with PS2_PARITY_CHECK_EN defined, check odd parity over 8 data bits plus the parity bit; on a mismatch it SHALL discard the byte and pulse err_parity.
REQ-033 SHALL, without PS2_PARITY_CHECK_EN, still sample the parity bit but ignore it, and tie err_parity to 0.

Verification
REQ-034 SHALL cover: frame 0x1C, parity 0 -> one entry code_data=0x1C, ext=0, brk=0; keycode_hist[7:0]=0x1C.
REQ-035 SHALL cover: bytes E0,F0,75 -> exactly one entry 0x75 with ext=1, brk=1; keycode_hist[23:0]=0xE0F075.
REQ-036 SHALL cover: 0x1C sent with parity 1, macro defined -> no push, one err_parity pulse; macro undefined -> 0x1C pushed.
REQ-037 SHALL cover: 5 data bits then idle for TIMEOUT_CYCLES -> one err_frame pulse, FSM in IDLE; the next good 0x29 frame is received correctly.
REQ-038 SHALL cover: DEPTH=4, code_ready=0, send 0x15,0x16,0x1E,0x26,0x25 -> fifo_count=4 and one overflow pulse; draining yields 15,16,1E,26.
REQ-039 SHALL cover: a 2-cycle low glitch on ps2_clk with FILTER_LEN=8 -> no fall strobe and no state change.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver.
// Synchronises and de-glitches the raw PS/2 lines, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues {ext,brk,byte} entries in a
// first-word-fall-through FIFO. Also keeps a raw byte history register.
// Build option: define PS2_PARITY_CHECK_EN to enable odd-parity checking.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a start bit (0) on a ps2_clk fall
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit, then accept or discard the byte
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int DEPTH          = 8,
    parameter int HIST_BYTES     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    output logic                         code_valid,
    input  logic                         code_ready,
    output logic [7:0]                   code_data,
    output logic                         code_ext,
    output logic                         code_brk,
    output logic [8*HIST_BYTES-1:0]      keycode_hist,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         err_parity,
    output logic                         err_frame,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [7:0]    FL_LAST = 8'(FILTER_LEN-1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES-1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t state, state_n;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_f, data_f, clk_f_q;
    logic [7:0]    clk_cnt, data_cnt;
    logic          fall;
    logic [TW-1:0] timer;
    logic          timeout;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          parity_bad;
    logic          shift_en, par_en, byte_ok, perr_c, ferr_c;
    logic          pend_ext, pend_brk;
    logic          is_prefix, push, pop, full, wr;
    logic [PW-1:0] wptr, rptr;
    logic [9:0]    mem [DEPTH];
    logic [8*HIST_BYTES+7:0] hist_shift;

    // Two-flop synchronisers; idle line level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // ps2_clk filter: follow the input only after FILTER_LEN differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f   <= 1'b1;
            clk_cnt <= '0;
        end else if (clk_sync[1] == clk_f) begin
            clk_cnt <= '0;
        end else if (clk_cnt == FL_LAST) begin
            clk_f   <= clk_sync[1];
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    // ps2_data filter, same rule as the clock filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_f   <= 1'b1;
            data_cnt <= '0;
        end else if (data_sync[1] == data_f) begin
            data_cnt <= '0;
        end else if (data_cnt == FL_LAST) begin
            data_f   <= data_sync[1];
            data_cnt <= '0;
        end else begin
            data_cnt <= data_cnt + 1'b1;
        end
    end

    assign fall = clk_f_q & ~clk_f;

    // Previous filtered clock for fall detection; inter-edge down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f_q <= 1'b1;
            timer   <= '0;
        end else begin
            clk_f_q <= clk_f;
            if (fall)
                timer <= TO_LOAD;
            else if (state != IDLE && timer != '0)
                timer <= timer - 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !fall && (timer == '0);

`ifdef PS2_PARITY_CHECK_EN
    assign parity_bad = ~(^{shreg, par_bit});
`else
    // Parity bit is still captured but does not affect acceptance here.
    logic unused_parity;
    assign unused_parity = par_bit;
    assign parity_bad    = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        par_en   = 1'b0;
        byte_ok  = 1'b0;
        perr_c   = 1'b0;
        ferr_c   = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            ferr_c  = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_f) state_n = DATA;
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_en  = 1'b1;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!data_f)         ferr_c  = 1'b1;
                    else if (parity_bad) perr_c  = 1'b1;
                    else                 byte_ok = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame datapath: bit counter, LSB-first shifter, parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == IDLE) bit_cnt <= '0;
            if (shift_en) begin
                shreg   <= {data_f, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_en) par_bit <= data_f;
        end
    end

    assign is_prefix  = (shreg == 8'hE0) || (shreg == 8'hF0);
    assign push       = byte_ok && !is_prefix;
    assign pop        = code_valid && code_ready;
    assign full       = (fifo_count == DEPTH_C);
    assign wr         = push && (!full || pop);
    assign hist_shift = {keycode_hist, shreg};

    // Prefix flags, history register and registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_ext     <= 1'b0;
            pend_brk     <= 1'b0;
            keycode_hist <= '0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            err_parity <= perr_c;
            err_frame  <= ferr_c;
            overflow   <= push && full && !pop;
            if (byte_ok) begin
                keycode_hist <= hist_shift[8*HIST_BYTES-1:0];
                if (shreg == 8'hE0) begin
                    pend_ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    pend_brk <= 1'b1;
                end else begin
                    pend_ext <= 1'b0;
                    pend_brk <= 1'b0;
                end
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= {pend_ext, pend_brk, shreg};
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (wr && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!wr && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    assign code_valid = (fifo_count != '0);
    assign {code_ext, code_brk, code_data} = code_valid ? mem[rptr] : 10'h000;

endmodule
